// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store execution unit.
package lsu_pkg;

    localparam int XLEN      = 32;
    localparam int CDB_TAG_W = 6;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        CDB
    } lsu_state_e;

    // The low two funct3 bits give the access size: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/ls_exec_unit.sv
// Single-outstanding load/store unit: accept an entry, do one memory access, optionally publish on the CDB.
// Define LSU_ALIGN_CHECK_EN to trap misaligned H/W accesses instead of truncating them to the word.
module ls_exec_unit
    import lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [XLEN-1:0]      ex_address,
    input  logic [XLEN-1:0]      ex_data,
    input  logic [CDB_TAG_W-1:0] rd_tag,
    input  logic                 rd_tag_valid,
    input  logic [2:0]           funct3,
    input  logic                 agu_ls,
    output logic                 ex_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_ack,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output logic                 cdb_valid,
    output logic [CDB_TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]      cdb_data,
    output logic                 misalign_err
);

    lsu_state_e           state_q, state_d;
    logic [XLEN-1:0]      addr_q, data_q, result_q, load_result;
    logic [CDB_TAG_W-1:0] tag_q;
    logic                 tag_valid_q, ls_q;
    logic [2:0]           funct3_q;
    logic                 accept, misaligned;

    assign accept = (state_q == IDLE) && issue_valid && !rst;

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned = is_misaligned(funct3[1:0], ex_address[1:0]);

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if (accept && misaligned)
            misalign_q <= 1'b1;
    end

    assign misalign_err = misalign_q;
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A trapped access bypasses memory; anything that publishes carries 0 unless a load completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    if (misaligned)
                        state_d = (!agu_ls || rd_tag_valid) ? CDB : IDLE;
                    else
                        state_d = MEM;
                end
            end
            MEM: begin
                if (mem_ack)
                    state_d = (!ls_q || tag_valid_q) ? CDB : IDLE;
            end
            CDB: begin
                if (cdb_grant)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            data_q      <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            funct3_q    <= '0;
            ls_q        <= 1'b0;
            result_q    <= '0;
        end else if (accept) begin
            addr_q      <= ex_address;
            data_q      <= ex_data;
            tag_q       <= rd_tag;
            tag_valid_q <= rd_tag_valid;
            funct3_q    <= funct3;
            ls_q        <= agu_ls;
            result_q    <= '0;
        end else if (state_q == MEM && mem_ack && !ls_q) begin
            result_q    <= load_result;
        end
    end

    always_comb begin
        ex_done   = accept;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        cdb_req   = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_data  = '0;
        case (state_q)
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = ls_q;
                mem_addr = {addr_q[XLEN-1:2], 2'b00};
                if (ls_q) begin
                    mem_be    = store_be(funct3_q[1:0], addr_q[1:0]);
                    mem_wdata = store_wdata(funct3_q[1:0], data_q);
                end else begin
                    mem_be    = 4'hF;
                end
            end
            CDB: begin
                cdb_req = 1'b1;
                if (cdb_grant) begin
                    cdb_valid = 1'b1;
                    cdb_tag   = tag_q;
                    cdb_data  = result_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed cases then randomized transactions against an arithmetic model.
module tb_ls_exec_unit;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] ex_address, ex_data;
    logic [5:0]  rd_tag;
    logic        rd_tag_valid;
    logic [2:0]  funct3;
    logic        agu_ls;
    logic        ex_done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        cdb_req, cdb_grant, cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        misalign_err;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_mis   = 1'b0;

    ls_exec_unit dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .ex_address   (ex_address),
        .ex_data      (ex_data),
        .rd_tag       (rd_tag),
        .rd_tag_valid (rd_tag_valid),
        .funct3       (funct3),
        .agu_ls       (agu_ls),
        .ex_done      (ex_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .cdb_req      (cdb_req),
        .cdb_grant    (cdb_grant),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Load result computed from shifts and masks, independent of any lane mux.
    function automatic logic [31:0] refLoad(input logic [31:0] rdata, input logic [31:0] addr, input logic [2:0] f3);
        int unsigned off = addr % 4;
        logic [31:0] b = (rdata >> (8 * off)) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] refBe(input logic [31:0] addr, input logic [2:0] f3, input logic ls);
        int unsigned off = addr % 4;
        if (!ls) return 32'hF;
        case (f3 % 4)
            0:       return 32'h1 << off;
            1:       return 32'h3 << (2 * (off / 2));
            default: return 32'hF;
        endcase
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] data, input logic [2:0] f3);
        case (f3 % 4)
            0:       return (data & 32'hFF) * 32'h0101_0101;
            1:       return (data & 32'hFFFF) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    function automatic logic refMisaligned(input logic [31:0] addr, input logic [2:0] f3);
        case (f3 % 4)
            0:       return 1'b0;
            1:       return (addr % 2) != 0;
            default: return (addr % 4) != 0;
        endcase
    endfunction

    task automatic scrambleIssue(input logic hold);
        issue_valid  = hold;
        ex_address   = $urandom;
        ex_data      = $urandom;
        rd_tag       = 6'($urandom);
        rd_tag_valid = 1'($urandom);
        funct3       = 3'($urandom);
        agu_ls       = 1'($urandom);
    endtask

    // One full entry: accept, memory phase with ack_dly wait cycles, optional CDB phase with grant_dly wait cycles.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [5:0] tag,
                                 input logic tagv, input logic [2:0] f3, input logic ls,
                                 input int ack_dly, input int grant_dly, input logic [31:0] rdata,
                                 input logic hold);
        logic skip_mem, publish;
        logic [31:0] exp_data;
        skip_mem = ALIGN_CHECK && refMisaligned(addr, f3);
        publish  = !ls || tagv;
        exp_data = (ls || skip_mem) ? 32'h0 : refLoad(rdata, addr, f3);

        issue_valid  = 1'b1;
        ex_address   = addr;
        ex_data      = data;
        rd_tag       = tag;
        rd_tag_valid = tagv;
        funct3       = f3;
        agu_ls       = ls;
        mem_ack      = 1'b0;
        cdb_grant    = 1'b0;
        #1;
        checkOutput("ex_done_accept", ex_done, 1);
        checkOutput("mem_req_idle", mem_req, 0);
        checkOutput("cdb_req_idle", cdb_req, 0);
        checkOutput("misalign_err", misalign_err, exp_mis);
        tick();
        if (skip_mem) exp_mis = 1'b1;

        if (!skip_mem) begin
            for (int i = 0; i <= ack_dly; i++) begin
                scrambleIssue(hold);
                mem_ack   = (i == ack_dly);
                mem_rdata = mem_ack ? rdata : $urandom;
                cdb_grant = 1'($urandom);
                #1;
                checkOutput("ex_done_mem", ex_done, 0);
                checkOutput("mem_req", mem_req, 1);
                checkOutput("mem_we", mem_we, ls);
                checkOutput("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                checkOutput("mem_be", mem_be, refBe(addr, f3, ls));
                if (ls) checkOutput("mem_wdata", mem_wdata, refWdata(data, f3));
                checkOutput("cdb_valid_mem", cdb_valid, 0);
                tick();
            end
        end
        mem_ack   = 1'b0;
        cdb_grant = 1'b0;

        if (publish) begin
            for (int j = 0; j <= grant_dly; j++) begin
                scrambleIssue(hold);
                cdb_grant = (j == grant_dly);
                #1;
                checkOutput("ex_done_cdb", ex_done, 0);
                checkOutput("mem_req_cdb", mem_req, 0);
                checkOutput("cdb_req", cdb_req, 1);
                checkOutput("cdb_valid", cdb_valid, cdb_grant);
                checkOutput("cdb_tag", cdb_tag, cdb_grant ? tag : 6'd0);
                checkOutput("cdb_data", cdb_data, cdb_grant ? exp_data : 32'd0);
                tick();
            end
        end
        cdb_grant   = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        issue_valid  = 1'b0;
        ex_address   = '0;
        ex_data      = '0;
        rd_tag       = '0;
        rd_tag_valid = 1'b0;
        funct3       = '0;
        agu_ls       = 1'b0;
        mem_rdata    = '0;
        mem_ack      = 1'b0;
        cdb_grant    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_ex_done", ex_done, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_be", mem_be, 0);
        checkOutput("rst_cdb_req", cdb_req, 0);
        checkOutput("rst_cdb_valid", cdb_valid, 0);
        checkOutput("rst_misalign", misalign_err, 0);
        tick();

        $display("[TB] directed: LB/LBU, SH, delayed LW, misaligned LW");
        applyStimulus(32'h0000_1003, 32'h0, 6'h03, 1'b1, 3'b000, 1'b0, 0, 0, 32'h80FF_1234, 1'b0);
        applyStimulus(32'h0000_1003, 32'h0, 6'h04, 1'b1, 3'b100, 1'b0, 0, 0, 32'h80FF_1234, 1'b0);
        applyStimulus(32'h0000_2002, 32'h1234_ABCD, 6'h00, 1'b0, 3'b001, 1'b1, 0, 0, 32'h0, 1'b0);
        applyStimulus(32'h0000_0040, 32'h0, 6'h15, 1'b1, 3'b010, 1'b0, 3, 2, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(32'h0000_3001, 32'h0, 6'h07, 1'b1, 3'b010, 1'b0, 1, 0, 32'h5555_AAAA, 1'b0);
        applyStimulus(32'h0000_0102, 32'h0, 6'h08, 1'b1, 3'b101, 1'b0, 0, 1, 32'h9ABC_7FFF, 1'b0);

        $display("[TB] directed: back-to-back issue held high");
        applyStimulus(32'h0000_0010, 32'h0, 6'h21, 1'b1, 3'b010, 1'b0, 0, 0, 32'h1111_1111, 1'b1);
        applyStimulus(32'h0000_0014, 32'hCAFE_F00D, 6'h22, 1'b1, 3'b010, 1'b1, 1, 0, 32'h0, 1'b1);
        applyStimulus(32'h0000_0019, 32'h0000_00A5, 6'h23, 1'b0, 3'b000, 1'b1, 0, 0, 32'h0, 1'b1);
        applyStimulus(32'h0000_001E, 32'h0, 6'h24, 1'b1, 3'b001, 1'b0, 0, 2, 32'h8001_0203, 1'b1);

        $display("[TB] directed: reset while waiting in MEM");
        ex_address   = 32'h0000_0080;
        rd_tag       = 6'h2A;
        rd_tag_valid = 1'b1;
        funct3       = 3'b010;
        agu_ls       = 1'b0;
        issue_valid  = 1'b1;
        tick();
        issue_valid = 1'b0;
        #1;
        checkOutput("pre_rst_mem_req", mem_req, 1);
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        exp_mis = 1'b0;
        #1;
        checkOutput("post_rst_mem_req", mem_req, 0);
        checkOutput("post_rst_cdb_req", cdb_req, 0);
        checkOutput("post_rst_misalign", misalign_err, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack   = 1'b0;
        cdb_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("late_ack_cdb_req", cdb_req, 0);
            checkOutput("late_ack_cdb_valid", cdb_valid, 0);
            checkOutput("late_ack_mem_req", mem_req, 0);
            tick();
        end
        cdb_grant = 1'b0;

        $display("[TB] randomized transactions");
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom, $urandom, 6'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                          1'($urandom));
        end

        #1;
        checkOutput("final_misalign", misalign_err, exp_mis);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ls_exec_unit.md
# ls_exec_unit

Load/store execution unit that consumes entries issued by the AGU reservation queue. It captures the computed address, store data, destination tag and access type, then performs one data-memory access over a req/ack handshake. Load results are published on the common data bus (CDB) after a request/grant arbitration. The unit has a single outstanding operation and returns `ex_done` to the queue when it accepts an entry.

## Interface
Parameters: none.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  queue head entry is valid
- ex_address  in  32  effective address (op1 + imm)
- ex_data  in  32  store data (op2)
- rd_tag  in  6  destination tag
- rd_tag_valid  in  1  destination tag valid
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- agu_ls  in  1  0 = load, 1 = store
- ex_done  out  1  accept strobe to queue, one cycle per entry
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word address {ex_address[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete
- cdb_req  out  1  CDB request
- cdb_grant  in  1  CDB grant
- cdb_valid  out  1  CDB publish strobe
- cdb_tag  out  6  published tag
- cdb_data  out  32  published data
- misalign_err  out  1  sticky misaligned-access flag

## Operation
- FSM states: IDLE, MEM, CDB.
- IDLE:
  - `ex_done = issue_valid` (combinational).
  - On an edge with `issue_valid`, capture all issue fields into internal registers and go to MEM.
- MEM:
  - Hold `mem_req=1`; `mem_we=agu_ls_q`.
  - On `mem_ack`:
    - Load: register the aligned result and go to CDB.
    - Store with `rd_tag_valid_q`: result is 0; go to CDB.
    - Store without `rd_tag_valid_q`: go to IDLE.
- CDB:
  - Hold `cdb_req=1`.
  - In a cycle with `cdb_grant`: `cdb_valid=1`, `cdb_tag=rd_tag_q`, `cdb_data=result_q`; go to IDLE.
  - Outside this case `cdb_valid=0`, and `cdb_tag` and `cdb_data` read 0.
- Store lanes:
  - B: `be=4'b0001<<addr[1:0]`, wdata = byte replicated ×4.
  - H: `be=4'b0011<<{addr[1],1'b0}`, wdata = half replicated ×2.
  - W: `be=4'hF`, wdata = data.
  - Loads drive `mem_be=4'hF`.
- Load align:
  - Select the byte by `addr[1:0]`, or the half by `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend.
  - funct3 011/110/111: treated as W.
- `ex_done` is never asserted outside IDLE.
- Issue inputs are ignored outside IDLE.

## Timing
- Reset: state=IDLE. All outputs 0, including `ex_done`, `mem_req`, `cdb_req`, `cdb_valid` and `misalign_err`. Captured registers are cleared.
- Reset mid-operation: the operation is abandoned and nothing is published. `mem_req` and `cdb_req` are 0 in the cycle after the reset edge. A late `mem_ack` in IDLE is ignored.
- Best-case load with zero-wait ack and grant:
  - Cycle 0: accept.
  - Cycle 1: `mem_req` and `mem_ack`.
  - Cycle 2: `cdb_req`, `cdb_grant` and `cdb_valid`.
  - Cycle 3: next accept possible.
- Best-case untagged store: accept in cycle 0, memory in cycle 1, next accept in cycle 2.
- Outputs hold stable across any number of mem and CDB wait cycles.
- `mem_ack` in the same cycle as the first `mem_req` is legal.
- `cdb_grant` without `cdb_req` is ignored.

## Configuration
- Macro: `LSU_ALIGN_CHECK_EN`.
- Defined: an accepted H/HU with `addr[0]=1`, or a W with `addr[1:0]!=0`, is handled as follows:
  - It skips MEM; no `mem_req` is issued.
  - A load or tagged store goes straight to CDB and publishes data 0.
  - An untagged store returns to IDLE.
  - `misalign_err` is set and remains set until `rst`.
- Undefined: no check is made. The low address bits select lanes exactly as in Operation. Accesses that cross a word boundary are truncated to the addressed word. `misalign_err` is tied to 0.

## Structure
- `lsu_pkg` holds:
  - the FSM state enum;
  - the funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - `CDB_TAG_W=6` and `XLEN=32`.
- Sub-module `lsu_load_align` (combinational): inputs are rdata, `addr[1:0]` and funct3; output is the 32-bit extended result. It is instantiated once.

## Test plan
- Reset while the FSM is held in MEM (no ack) → `mem_req` is 0 in the next cycle. A following `mem_ack` produces no CDB publish.
- LB at `0x1003` with rdata `0x80FF_1234` → `mem_addr=0x1000`, `cdb_data=0xFFFF_FF80`. The LBU variant gives `0x0000_0080`.
- SH at `0x2002`, data `0x1234_ABCD`, tag invalid → `mem_be=4'b1100`, `mem_wdata=0xABCD_ABCD`, `mem_we=1`. No `cdb_req`. Next accept two cycles after the first one.
- LW to tag 0x15, with `mem_ack` delayed 3 cycles and `cdb_grant` delayed 2 → exactly one `cdb_valid` with tag 0x15. `ex_done` pulses exactly once for the entry.
- Back-to-back `issue_valid` held high → `ex_done` pulses only in IDLE cycles. Each entry is published in order.
- With `LSU_ALIGN_CHECK_EN`: LW at `0x3001` → no `mem_req`; `cdb_data=0`; `misalign_err=1` until reset.
